// File: rtl/f8_ram_arbiter.sv
// Shares the single-port system RAM between the f8 core (A) and a bus master (B).
// A has priority; B is protected by a bounded wait counter; a_lock pins the RAM to A.
module f8_ram_arbiter #(
   parameter int RAMADDRBITS = 13,
   parameter int MAXWAIT     = 4
) (
   input  logic                   clk,
   input  logic                   power_on_reset,
   input  logic                   a_req,
   input  logic                   a_we,
   input  logic [RAMADDRBITS-1:0] a_addr,
   input  logic [7:0]             a_wdata,
   input  logic                   a_lock,
   output logic                   a_gnt,
   output logic                   a_rvalid,
   input  logic                   b_req,
   input  logic                   b_we,
   input  logic [RAMADDRBITS-1:0] b_addr,
   input  logic [7:0]             b_wdata,
   output logic                   b_gnt,
   output logic                   b_rvalid,
   output logic [7:0]             rdata,
   output logic                   ram_en,
   output logic                   ram_we,
   output logic [RAMADDRBITS-1:0] ram_addr,
   output logic [7:0]             ram_wdata,
   input  logic [7:0]             ram_rdata
);

   localparam int WW = $clog2(MAXWAIT + 1);
   localparam logic [WW-1:0] WMAX = WW'(MAXWAIT);

   logic                   lock_hold;
   logic [WW-1:0]          waitcnt;
   logic                   rd_a;
   logic                   rd_b;
   logic [RAMADDRBITS-1:0] addr_q;
   logic [7:0]             wdata_q;
   logic                   b_wins;

   always_comb begin
      b_wins    = !lock_hold && (waitcnt == WMAX);
      a_gnt     = 1'b0;
      b_gnt     = 1'b0;
      if (!power_on_reset) begin
         a_gnt = a_req && (!b_req || !b_wins);
         b_gnt = b_req && (!a_req || b_wins);
      end
      ram_en    = a_gnt || b_gnt;
      ram_we    = 1'b0;
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
      if (a_gnt) begin
         ram_we    = a_we;
         ram_addr  = a_addr;
         ram_wdata = a_wdata;
      end else if (b_gnt) begin
         ram_we    = b_we;
         ram_addr  = b_addr;
         ram_wdata = b_wdata;
      end
   end

   always_ff @(posedge clk or posedge power_on_reset) begin
      if (power_on_reset) begin
         lock_hold <= 1'b0;
         waitcnt   <= '0;
         rd_a      <= 1'b0;
         rd_b      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         if (a_gnt && a_lock)
            lock_hold <= 1'b1;
         else if (!a_lock || b_gnt)
            lock_hold <= 1'b0;
         // Saturating count of consecutive refused B cycles
         if (b_req && !b_gnt) begin
            if (waitcnt != WMAX)
               waitcnt <= waitcnt + 1'b1;
         end else begin
            waitcnt <= '0;
         end
         rd_a <= a_gnt && !a_we;
         rd_b <= b_gnt && !b_we;
         if (ram_en) begin
            addr_q  <= ram_addr;
            wdata_q <= ram_wdata;
         end
      end
   end

   assign a_rvalid = rd_a;
   assign b_rvalid = rd_b;
   assign rdata    = (rd_a || rd_b) ? ram_rdata : 8'h00;

endmodule
